// File: rtl/ihm_pkg.sv
// ihm_pkg: motor panel FSM state encoding and 7-segment (active-low, gfedcba) level decode
package ihm_pkg;

   typedef enum logic [1:0] {STANDBY, RUNNING, BRAKE} state_t;

   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0011000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;

   function automatic logic [6:0] seg_decode(input logic [7:0] lvl);
      logic [6:0] s;
      case (lvl)
         8'd0:    s = SEG_0;
         8'd1:    s = SEG_1;
         8'd2:    s = SEG_2;
         8'd3:    s = SEG_3;
         8'd4:    s = SEG_4;
         8'd5:    s = SEG_5;
         8'd6:    s = SEG_6;
         8'd7:    s = SEG_7;
         8'd8:    s = SEG_8;
         8'd9:    s = SEG_9;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-FF synchroniser for an asynchronous panel input, plus rising-edge detect
module btn_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level_s,
   output logic rise
);

   logic meta;
   logic prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta    <= 1'b0;
         level_s <= 1'b0;
         prev    <= 1'b0;
      end else begin
         meta    <= pin;
         level_s <= meta;
         prev    <= level_s;
      end
   end

   assign rise = level_s & ~prev;

endmodule

// File: rtl/pwm_motor_ctrl.sv
// pwm_motor_ctrl: start/stop switch and inc/dec buttons to a counter-based PWM motor drive.
// Define IHM_SEVEN_SEG_EN to add the registered 7-segment level display output.
module pwm_motor_ctrl
   import ihm_pkg::*;
#(
   parameter int MAX_LEVEL   = 9,
   parameter int START_LEVEL = 5,
   parameter int STEP        = 16,
   parameter int LEVEL_W     = 4,
   parameter int CNT_W       = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               swt_start_stop,
   input  logic               swt_increase,
   input  logic               swt_decrease,
   output logic               motor_pwm,
   output logic               motor_running,
   output logic [LEVEL_W-1:0] level
`ifdef IHM_SEVEN_SEG_EN
   ,
   output logic [6:0]         display
`endif
);

   localparam logic [CNT_W-1:0]   LAST      = CNT_W'(MAX_LEVEL * STEP - 1);
   localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(MAX_LEVEL);
   localparam logic [LEVEL_W-1:0] LVL_START = LEVEL_W'(START_LEVEL);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [LEVEL_W-1:0] duty;
   logic               hold;
   logic               start_s, inc_s, dec_s;
   logic               inc_rise, dec_rise, start_rise_unused;
   logic [CNT_W:0]     thr;
   logic               high;
   logic               wrap;

   btn_sync_edge u_start (.clk(clk), .rst(rst), .pin(swt_start_stop), .level_s(start_s), .rise(start_rise_unused));
   btn_sync_edge u_inc   (.clk(clk), .rst(rst), .pin(swt_increase),   .level_s(inc_s),   .rise(inc_rise));
   btn_sync_edge u_dec   (.clk(clk), .rst(rst), .pin(swt_decrease),   .level_s(dec_s),   .rise(dec_rise));

   assign thr  = (CNT_W+1)'(duty) * (CNT_W+1)'(STEP);
   assign high = {1'b0, cnt} < thr;
   assign wrap = cnt == LAST;

   // duty only follows level on the wrap edge; hold blanks the rest of a period after a brake release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= STANDBY;
         level         <= '0;
         duty          <= '0;
         cnt           <= '0;
         hold          <= 1'b0;
         motor_pwm     <= 1'b0;
         motor_running <= 1'b0;
      end else begin
         case (state)
            STANDBY: begin
               if (start_s) begin
                  state         <= RUNNING;
                  level         <= LVL_START;
                  duty          <= LVL_START;
                  cnt           <= '0;
                  hold          <= 1'b0;
                  motor_running <= 1'b1;
               end
            end
            default: begin
               if (!start_s) begin
                  state         <= STANDBY;
                  level         <= '0;
                  cnt           <= '0;
                  motor_pwm     <= 1'b0;
                  motor_running <= 1'b0;
               end else begin
                  cnt <= wrap ? '0 : cnt + CNT_W'(1);
                  if (wrap) duty <= level;
                  if (state == BRAKE) begin
                     motor_pwm <= 1'b0;
                     if (!inc_s && !dec_s) begin
                        state <= RUNNING;
                        hold  <= !wrap;
                     end
                  end else if (inc_s && dec_s) begin
                     state     <= BRAKE;
                     motor_pwm <= 1'b0;
                  end else begin
                     motor_pwm <= high && !hold;
                     if (wrap) hold <= 1'b0;
                     if (inc_rise && level < LVL_MAX) level <= level + LEVEL_W'(1);
                     else if (dec_rise && level != '0) level <= level - LEVEL_W'(1);
                  end
               end
            end
         endcase
      end
   end

`ifdef IHM_SEVEN_SEG_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) display <= SEG_0;
      else display <= seg_decode(8'(level));
   end
`endif

endmodule

// File: tb/tb_pwm_motor_ctrl.sv
// tb_pwm_motor_ctrl: directed + randomised bench; reference derives PWM phase from cycle arithmetic
module tb_pwm_motor_ctrl;

   localparam int MAX_LEVEL   = 9;
   localparam int START_LEVEL = 5;
   localparam int STEP        = 16;
   localparam int P           = MAX_LEVEL * STEP;
   localparam int M_STBY = 0, M_RUN = 1, M_BRK = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_pin = 1'b0, inc_pin = 1'b0, dec_pin = 1'b0;
   logic       motor_pwm, motor_running;
   logic [3:0] level;
`ifdef IHM_SEVEN_SEG_EN
   logic [6:0] display;
   logic [6:0] e_disp;
   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};
`endif

   int         n_tests = 0, n_fail = 0;
   int         mode, lvl, duty;
   logic       e_pwm;
   longint     k, t0, rel_idx;
   logic [2:0] hs, hi, hd;

   pwm_motor_ctrl dut (
      .clk(clk),
      .rst(rst),
      .swt_start_stop(start_pin),
      .swt_increase(inc_pin),
      .swt_decrease(dec_pin),
      .motor_pwm(motor_pwm),
      .motor_running(motor_running),
      .level(level)
`ifdef IHM_SEVEN_SEG_EN
      ,
      .display(display)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      mode = M_STBY; lvl = 0; duty = 0; e_pwm = 1'b0;
      k = 0; t0 = 0; rel_idx = -1;
      hs = '0; hi = '0; hd = '0;
`ifdef IHM_SEVEN_SEG_EN
      e_disp = seg_tab[0];
`endif
   endfunction

   // one clock edge: pins seen by the decision are those sampled two edges earlier
   function automatic void model_step();
      int     c, old;
      longint idx;
      old = lvl;
      k++;
`ifdef IHM_SEVEN_SEG_EN
      e_disp = old > 9 ? 7'b0111111 : seg_tab[old];
`endif
      if (mode == M_STBY) begin
         e_pwm = 1'b0;
         if (hs[1]) begin
            mode = M_RUN; lvl = START_LEVEL; duty = START_LEVEL; t0 = k; rel_idx = -1;
         end
      end else if (!hs[1]) begin
         mode = M_STBY; lvl = 0; e_pwm = 1'b0;
      end else begin
         c   = int'((k - t0 - 1) % P);
         idx = (k - t0 - 1) / P;
         if (mode == M_BRK) begin
            e_pwm = 1'b0;
            if (!hi[1] && !hd[1]) begin mode = M_RUN; rel_idx = idx; end
         end else if (hi[1] && hd[1]) begin
            mode = M_BRK; e_pwm = 1'b0;
         end else begin
            e_pwm = (idx > rel_idx) && (c < duty * STEP);
            if (hi[1] && !hi[2]) lvl = lvl < MAX_LEVEL ? lvl + 1 : lvl;
            else if (hd[1] && !hd[2]) lvl = lvl > 0 ? lvl - 1 : 0;
         end
         if (c == P - 1) duty = old;
      end
      hs = {hs[1:0], start_pin};
      hi = {hi[1:0], inc_pin};
      hd = {hd[1:0], dec_pin};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("pwm", motor_pwm, e_pwm);
      check("running", motor_running, mode != M_STBY);
      check("level", level, lvl);
`ifdef IHM_SEVEN_SEG_EN
      check("display", display, e_disp);
`endif
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic press(input bit up);
      if (up) inc_pin = 1'b1; else dec_pin = 1'b1;
      ticks(2);
      inc_pin = 1'b0;
      dec_pin = 1'b0;
      ticks(4);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi_cnt, w;
      model_reset();
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_pwm", motor_pwm, 0);
      check("rst_running", motor_running, 0);
      check("rst_level", level, 0);
`ifdef IHM_SEVEN_SEG_EN
      check("rst_display", display, 7'b1000000);
`endif
      rst = 1'b1;
      ticks(3);

      start_pin = 1'b1;
      ticks(2);
      check("start_early", motor_running, 0);
      tick();
      check("start_running", motor_running, 1);
      check("start_level", level, START_LEVEL);
      hi_cnt = 0;
      repeat (P) begin tick(); hi_cnt += int'(motor_pwm); end
      check("duty5_high", hi_cnt, 80);

      hi_cnt = 0;
      for (int i = 0; i < P; i++) begin
         inc_pin = (i >= 38 && i < 40);
         tick();
         hi_cnt += int'(motor_pwm);
      end
      check("midinc_cur", hi_cnt, 80);
      check("midinc_level", level, 6);
      hi_cnt = 0;
      repeat (P) begin tick(); hi_cnt += int'(motor_pwm); end
      check("midinc_next", hi_cnt, 96);

      press(1'b0);
      check("back_to_5", level, 5);
      for (int i = 1; i <= 6; i++) begin
         press(1'b1);
         check("inc_level", level, (5 + i > MAX_LEVEL) ? MAX_LEVEL : 5 + i);
      end
      ticks(P);
      hi_cnt = 0;
      repeat (P) begin tick(); hi_cnt += int'(motor_pwm); end
      check("duty9_high", hi_cnt, P);

      inc_pin = 1'b1;
      dec_pin = 1'b1;
      ticks(4);
      check("brake_running", motor_running, 1);
      check("brake_pwm", motor_pwm, 0);
      check("brake_level", level, 9);
      hi_cnt = 0;
      repeat (50) begin tick(); hi_cnt += int'(motor_pwm); end
      check("brake_quiet", hi_cnt, 0);
      check("brake_level_held", level, 9);
      inc_pin = 1'b0;
      dec_pin = 1'b0;
      ticks(P + 3);
      hi_cnt = 0;
      repeat (P) begin tick(); hi_cnt += int'(motor_pwm); end
      check("resume_high", hi_cnt, P);

      press(1'b0);
      press(1'b0);
      check("level7", level, 7);
      ticks(30);
      start_pin = 1'b0;
      ticks(3);
      check("stop_pwm", motor_pwm, 0);
      check("stop_running", motor_running, 0);
      check("stop_level", level, 0);
      repeat (10) press(1'b0);
      check("stby_dec_level", level, 0);
      check("stby_running", motor_running, 0);

      start_pin = 1'b1;
      w = 0;
      while (motor_pwm !== 1'b1 && w < 400) begin tick(); w++; end
      check("wait_high", motor_pwm, 1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_pwm", motor_pwm, 0);
      check("async_rst_level", level, 0);
      check("async_rst_running", motor_running, 0);
`ifdef IHM_SEVEN_SEG_EN
      check("async_rst_display", display, 7'b1000000);
`endif
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      ticks(4);
      check("restart_level", level, START_LEVEL);
      for (int i = 1; i <= 5; i++) begin press(1'b0); check("sweep_down", level, 5 - i); end
      for (int i = 1; i <= 9; i++) begin press(1'b1); check("sweep_up", level, i); end

      repeat (6000) begin
         if ($urandom_range(0, start_pin ? 600 : 30) == 0) start_pin = ~start_pin;
         if ($urandom_range(0, 9) == 0) inc_pin = ~inc_pin;
         if ($urandom_range(0, 9) == 0) dec_pin = ~dec_pin;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
